pending_encoder: RTL

//  Parametrised, registered successor to the team's 8-to-3 one-hot encoder.

---
 rtl/pending_encoder_pkg.sv | 14 +
 rtl/pending_encoder_if.sv | 23 ++
 rtl/pending_encoder_prio_search.sv | 37 +++
 rtl/pending_encoder.sv | 111 +++++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared types and helpers for the pending encoder: FSM state encoding and
// a width helper that never returns zero.
package pending_encoder_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pending_encoder_if.sv
// Output handshake and status bundle of the pending encoder.
interface pending_encoder_if #(
  parameter int N = 8
);
  import pending_encoder_pkg::*;
  localparam int W = clog2_min1(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         overflow;

  modport master (
    output out_valid, out_idx, pending, overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_idx, pending, overflow,
    output out_ready
  );
endinterface

// File: rtl/pending_encoder_prio_search.sv
// Combinational find-first-set over N bits, searching upward from start and
// wrapping from N-1 to 0. start must be < N.
module prio_search
  import pending_encoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]               vec,
  input  logic [clog2_min1(N)-1:0]   start,
  output logic                       found,
  output logic [clog2_min1(N)-1:0]   idx
);
  localparam int W = clog2_min1(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  // Rotate so that bit 0 of rot is vec[start]; lowest set bit of rot wins.
  always_comb begin
    dbl   = {vec, vec} >> start;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(start) + off;
    if (sum >= N) sum = sum - N;
    idx = W'(sum);
  end

endmodule

// File: rtl/pending_encoder.sv
// Sticky request latch with one-at-a-time valid/ready index output.
// Define RR_PRIORITY_EN for round-robin search; default is lowest-index-first.
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          clr_all,
  pending_encoder_if.master o
);
  localparam int W = clog2_min1(N);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] pop_mask;
  logic         overflow_q, overflow_d;
  state_e       state_q;
  logic         out_valid_q;
  logic [W-1:0] out_idx_q;
  logic         pop;
  logic         found;
  logic [W-1:0] start;
  logic [W-1:0] srch_idx;

  assign pop = out_valid_q & o.out_ready;

  // A same-cycle request on the popped bit re-sets it, so it is never lost.
  always_comb begin
    pop_mask   = pop ? (N'(1) << out_idx_q) : '0;
    pending_d  = (pending_q & ~pop_mask) | (en ? req : '0);
    overflow_d = en & (|(req & pending_q & ~pop_mask));
    if (clr_all) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end
  end

`ifdef RR_PRIORITY_EN
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pop && !clr_all)
      rr_ptr_d = (int'(out_idx_q) == N - 1) ? '0 : out_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  prio_search #(.N(N)) u_search (
    .vec   (pending_q),
    .start (start),
    .found (found),
    .idx   (srch_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // The presented index is frozen in PRESENT; newer arrivals wait for IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else if (clr_all) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            out_idx_q   <= srch_idx;
            out_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o.out_valid = out_valid_q;
  assign o.out_idx   = out_idx_q;
  assign o.pending   = pending_q;
  assign o.overflow  = overflow_q;

endmodule
